// File: rtl/arf_rat_pkg.sv
// arf_rat_pkg
// Shared definitions for the architectural register file / register alias
// table block: widths, index/data types and the RAT entry record.
package arf_rat_pkg;

  localparam int N_ARF_REGS     = 32;
  localparam int ARF_ID_WIDTH   = 5;
  localparam int ROB_ID_WIDTH   = 4;
  localparam int REG_DATA_WIDTH = 32;

  localparam int ARF_N_REGS    = N_ARF_REGS;
  localparam int ROB_N_ENTRIES = 1 << ROB_ID_WIDTH;

  typedef logic [ARF_ID_WIDTH-1:0]   arf_id_t;
  typedef logic [ROB_ID_WIDTH-1:0]   rob_id_t;
  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

  // One alias-table entry: when valid, the architectural register's newest
  // value is still in flight and will be produced by ROB entry rob_id.
  typedef struct packed {
    logic    valid;
    rob_id_t rob_id;
  } rat_entry_t;

endpackage

// File: rtl/arf_rat_rat_table.sv
// rat_table
// Register alias table: one {valid, rob_id} entry per architectural register.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rd1_id/rd1, rd2_id/rd2   two combinational lookup ports
//   disp_we/disp_id/disp_rob_id  dispatch write (records a new mapping)
//   clr_en/clr_id/clr_rob_id     retire clear (only if mapping still matches)
//   flush                    drop every mapping at the next edge
// Entry 0 (x0) is constant and never renamed.
module rat_table
  import arf_rat_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  arf_id_t    rd1_id,
  output rat_entry_t rd1,
  input  arf_id_t    rd2_id,
  output rat_entry_t rd2,
  input  logic       disp_we,
  input  arf_id_t    disp_id,
  input  rob_id_t    disp_rob_id,
  input  logic       clr_en,
  input  arf_id_t    clr_id,
  input  rob_id_t    clr_rob_id,
  input  logic       flush
);

  logic    entry_valid [N_ARF_REGS];
  rob_id_t entry_rob   [N_ARF_REGS];

  genvar gi;
  generate
    for (gi = 0; gi < N_ARF_REGS; gi++) begin : g_entry
      if (gi == 0) begin : g_zero
        assign entry_valid[gi] = 1'b0;
        assign entry_rob[gi]   = '0;
      end else begin : g_reg
        logic    valid_reg;
        rob_id_t rob_reg;

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            valid_reg <= 1'b0;
            rob_reg   <= '0;
          end else if (flush) begin
            // Flush squashes any same-cycle dispatch; rob_id is left as a
            // don't-care behind valid=0.
            valid_reg <= 1'b0;
          end else if (disp_we && disp_id == arf_id_t'(gi)) begin
            // A new mapping overrides both an older mapping and a same-cycle
            // retire clear of the same register.
            valid_reg <= 1'b1;
            rob_reg   <= disp_rob_id;
          end else if (clr_en && clr_id == arf_id_t'(gi) && valid_reg &&
                       rob_reg == clr_rob_id) begin
            // Only clear if the retiring instruction is still the newest
            // producer; a younger mapping must survive.
            valid_reg <= 1'b0;
          end
        end

        assign entry_valid[gi] = valid_reg;
        assign entry_rob[gi]   = rob_reg;
      end
    end
  endgenerate

  assign rd1 = '{valid: entry_valid[rd1_id], rob_id: entry_rob[rd1_id]};
  assign rd2 = '{valid: entry_valid[rd2_id], rob_id: entry_rob[rd2_id]};

endmodule

// File: rtl/arf_rat.sv
// arf_rat
// Architectural register file plus register alias table.
// Ports:
//   clk, rst_aH                      clock, asynchronous active-high reset
//   dispatch_fire/_dst_valid/_dst_arf_id/_rob_id  rename a destination
//   srcN_arf_id -> srcN_renamed/_rob_id/_arf_data  zero-latency lookups
//   retire/_rob_id/_arf_id/_reg_data  commit a retired result
//   flush                             discard all speculative mappings
// Lookups read registered state only; same-cycle dispatch/retire are not
// bypassed (the ROB still holds a retiring value, and a same-cycle dispatch
// is younger than the looking-up instruction).
module arf_rat
  import arf_rat_pkg::*;
(
  input  logic      clk,
  input  logic      rst_aH,
  input  logic      dispatch_fire,
  input  logic      dispatch_dst_valid,
  input  arf_id_t   dispatch_dst_arf_id,
  input  rob_id_t   dispatch_rob_id,
  input  arf_id_t   src1_arf_id,
  output logic      src1_renamed,
  output rob_id_t   src1_rob_id,
  output reg_data_t src1_arf_data,
  input  arf_id_t   src2_arf_id,
  output logic      src2_renamed,
  output rob_id_t   src2_rob_id,
  output reg_data_t src2_arf_data,
  input  logic      retire,
  input  rob_id_t   retire_rob_id,
  input  arf_id_t   retire_arf_id,
  input  reg_data_t retire_reg_data,
  input  logic      flush
);

  logic       disp_we;
  logic       ret_we;
  rat_entry_t rat_rd1;
  rat_entry_t rat_rd2;
  reg_data_t  arf_data [N_ARF_REGS];

  // x0 is excluded by the table/array structure itself (entry 0 has no
  // storage), so the enables need no x0 qualification.
  assign disp_we = dispatch_fire && dispatch_dst_valid;
  assign ret_we  = retire;

  rat_table u_rat_table (
    .clk         (clk),
    .rst         (rst_aH),
    .rd1_id      (src1_arf_id),
    .rd1         (rat_rd1),
    .rd2_id      (src2_arf_id),
    .rd2         (rat_rd2),
    .disp_we     (disp_we),
    .disp_id     (dispatch_dst_arf_id),
    .disp_rob_id (dispatch_rob_id),
    .clr_en      (ret_we),
    .clr_id      (retire_arf_id),
    .clr_rob_id  (retire_rob_id),
    .flush       (flush)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_ARF_REGS; gi++) begin : g_arf
      if (gi == 0) begin : g_zero
        assign arf_data[gi] = '0;
      end else begin : g_reg
        reg_data_t data_reg;

        // Retire commits even during a flush: the retiring instruction is
        // older than the mispredict.
        always_ff @(posedge clk or posedge rst_aH) begin
          if (rst_aH) begin
            data_reg <= '0;
          end else if (ret_we && retire_arf_id == arf_id_t'(gi)) begin
            data_reg <= retire_reg_data;
          end
        end

        assign arf_data[gi] = data_reg;
      end
    end
  endgenerate

  assign src1_renamed  = rat_rd1.valid;
  assign src1_rob_id   = rat_rd1.rob_id;
  assign src1_arf_data = arf_data[src1_arf_id];
  assign src2_renamed  = rat_rd2.valid;
  assign src2_rob_id   = rat_rd2.rob_id;
  assign src2_arf_data = arf_data[src2_arf_id];

endmodule

// File: tb/tb_arf_rat.sv
// tb_arf_rat
// Directed bench for arf_rat: linear sequence of steps with hand-computed
// expected values, each checked with an immediate assertion.
module tb_arf_rat;
  import arf_rat_pkg::*;

  logic      clk = 1'b0;
  logic      rst_aH;
  logic      dispatch_fire;
  logic      dispatch_dst_valid;
  arf_id_t   dispatch_dst_arf_id;
  rob_id_t   dispatch_rob_id;
  arf_id_t   src1_arf_id;
  logic      src1_renamed;
  rob_id_t   src1_rob_id;
  reg_data_t src1_arf_data;
  arf_id_t   src2_arf_id;
  logic      src2_renamed;
  rob_id_t   src2_rob_id;
  reg_data_t src2_arf_data;
  logic      retire;
  rob_id_t   retire_rob_id;
  arf_id_t   retire_arf_id;
  reg_data_t retire_reg_data;
  logic      flush;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  arf_rat dut (
    .clk                 (clk),
    .rst_aH              (rst_aH),
    .dispatch_fire       (dispatch_fire),
    .dispatch_dst_valid  (dispatch_dst_valid),
    .dispatch_dst_arf_id (dispatch_dst_arf_id),
    .dispatch_rob_id     (dispatch_rob_id),
    .src1_arf_id         (src1_arf_id),
    .src1_renamed        (src1_renamed),
    .src1_rob_id         (src1_rob_id),
    .src1_arf_data       (src1_arf_data),
    .src2_arf_id         (src2_arf_id),
    .src2_renamed        (src2_renamed),
    .src2_rob_id         (src2_rob_id),
    .src2_arf_data       (src2_arf_data),
    .retire              (retire),
    .retire_rob_id       (retire_rob_id),
    .retire_arf_id       (retire_arf_id),
    .retire_reg_data     (retire_reg_data),
    .flush               (flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle();
    dispatch_fire       = 1'b0;
    dispatch_dst_valid  = 1'b0;
    dispatch_dst_arf_id = '0;
    dispatch_rob_id     = '0;
    retire              = 1'b0;
    retire_rob_id       = '0;
    retire_arf_id       = '0;
    retire_reg_data     = '0;
    flush               = 1'b0;
  endtask

  // Apply the currently driven controls for one edge, then return to idle.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_dispatch(input arf_id_t dst, input rob_id_t rob);
    dispatch_fire       = 1'b1;
    dispatch_dst_valid  = 1'b1;
    dispatch_dst_arf_id = dst;
    dispatch_rob_id     = rob;
  endtask

  task automatic set_retire(input rob_id_t rob, input arf_id_t dst, input reg_data_t d);
    retire          = 1'b1;
    retire_rob_id   = rob;
    retire_arf_id   = dst;
    retire_reg_data = d;
  endtask

  initial begin
    idle();
    src1_arf_id = '0;
    src2_arf_id = '0;
    rst_aH = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_aH = 1'b0;

    // 1. Reset state
    src1_arf_id = 5'd5; src2_arf_id = 5'd0; #1;
    chk("rst_s1_ren", 32'(src1_renamed), 32'd0);
    chk("rst_s1_data", src1_arf_data, 32'd0);
    chk("rst_s2_ren", 32'(src2_renamed), 32'd0);
    chk("rst_s2_data", src2_arf_data, 32'd0);

    // 2. Dispatch x5->rob3, then retire rob3 with 0xDEADBEEF
    set_dispatch(5'd5, 4'd3); step();
    chk("d5_ren", 32'(src1_renamed), 32'd1);
    chk("d5_rob", 32'(src1_rob_id), 32'd3);
    set_retire(4'd3, 5'd5, 32'hDEADBEEF); step();
    chk("r5_ren", 32'(src1_renamed), 32'd0);
    chk("r5_data", src1_arf_data, 32'hDEADBEEF);

    // 3. Retire of an older producer keeps the younger mapping
    set_dispatch(5'd7, 4'd2); step();
    set_dispatch(5'd7, 4'd6); step();
    set_retire(4'd2, 5'd7, 32'h11); step();
    src1_arf_id = 5'd7; #1;
    chk("x7_ren", 32'(src1_renamed), 32'd1);
    chk("x7_rob", 32'(src1_rob_id), 32'd6);
    chk("x7_data", src1_arf_data, 32'h11);

    // 4. Same-cycle retire and dispatch to x9
    set_retire(4'd4, 5'd9, 32'h22);
    set_dispatch(5'd9, 4'd8);
    src2_arf_id = 5'd9; #1;
    chk("x9_nobypass", 32'(src2_renamed), 32'd0);
    step();
    chk("x9_ren", 32'(src2_renamed), 32'd1);
    chk("x9_rob", 32'(src2_rob_id), 32'd8);
    chk("x9_data", src2_arf_data, 32'h22);

    // 5. Flush with same-cycle dispatch and retire
    set_dispatch(5'd1, 4'd1); step();
    set_dispatch(5'd2, 4'd2); step();
    src1_arf_id = 5'd1; src2_arf_id = 5'd2; #1;
    chk("x1_pre_ren", 32'(src1_renamed), 32'd1);
    chk("x2_pre_rob", 32'(src2_rob_id), 32'd2);
    flush = 1'b1;
    set_dispatch(5'd3, 4'd3);
    set_retire(4'd1, 5'd1, 32'h55);
    step();
    chk("fl_x1_ren", 32'(src1_renamed), 32'd0);
    chk("fl_x1_data", src1_arf_data, 32'h55);
    chk("fl_x2_ren", 32'(src2_renamed), 32'd0);
    src1_arf_id = 5'd3; #1;
    chk("fl_x3_ren", 32'(src1_renamed), 32'd0);
    src1_arf_id = 5'd9; #1;
    chk("fl_x9_ren", 32'(src1_renamed), 32'd0);
    chk("fl_x9_data", src1_arf_data, 32'h22);

    // 6. x0 writes are ignored
    set_dispatch(5'd0, 4'd5);
    set_retire(4'd5, 5'd0, 32'hFFFF);
    step();
    src1_arf_id = 5'd0; #1;
    chk("x0_ren", 32'(src1_renamed), 32'd0);
    chk("x0_data", src1_arf_data, 32'd0);

    // 7. Reset pulsed between edges clears state without a clock edge
    set_dispatch(5'd4, 4'd7); step();
    src1_arf_id = 5'd4; src2_arf_id = 5'd5; #1;
    chk("x4_ren_pre", 32'(src1_renamed), 32'd1);
    @(negedge clk);
    rst_aH = 1'b1; #1;
    chk("arst_x4_ren", 32'(src1_renamed), 32'd0);
    chk("arst_x5_data", src2_arf_data, 32'd0);
    rst_aH = 1'b0;
    src2_arf_id = 5'd1; #1;
    chk("arst_x1_data", src2_arf_data, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
